dff_pipe_async_reset: RTL and testbench
=======================================

// Module: dff_pipe_async_reset
// PURPOSE
//  Parametrised successor to the single async-reset D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
//  Each stage carries a valid bit; valid/ready handshake on both ends gives stall/backpressure.
//  Used as a retiming / delay line between blocks on one clock domain.
//  Full throughput: one word per cycle when the downstream end is always ready.
// PARAMETERS
//  WIDTH        8     data width in bits, >=1
//  DEPTH        3     number of register stages, >=1; elaboration error if 0
//  RESET_VALUE  '0    value loaded into every data register on reset (WIDTH bits)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset (0 = in reset)
//  data         in   WIDTH  input word
//  data_valid   in   1      input word valid
//  data_ready   out  1      pipeline can accept input this cycle
//  q            out  WIDTH  output word = stage DEPTH-1 data register
//  q_valid      out  1      q holds a valid word
//  q_ready      in   1      downstream accepts q this cycle
//  occupancy    out  $clog2(DEPTH+1)  valid stages count (only with DFF_PIPE_OCCUPANCY_EN)
// BEHAVIOUR
//  - Reset (reset==0, asynchronous, no clk needed): all valid bits=0, all data regs=RESET_VALUE.
//    So q=RESET_VALUE, q_valid=0, and occupancy=0.
//    On reset release, the first load occurs on the first clk rise with reset==1.
//  - Stage i advance: adv[i] = !v[i] || adv[i+1]. For the last stage, adv[DEPTH] = q_ready.
//    The ready chain is combinational from q_ready down to data_ready.
//  - data_ready = adv[0]. Transfer in = data_valid && data_ready. Transfer out = q_valid && q_ready.
//  - When adv[i] is high, stage i loads from stage i-1 (stage 0 loads from data/data_valid).
//    The stage takes both data and valid. The data reg is written only when its incoming valid=1.
//    Bubbles do not overwrite data.
//  - When adv[i] is low, stage i holds data and valid unchanged.
//  - Latency: a word accepted at edge N appears on q with q_valid=1 after edge N+DEPTH-1.
//    This assumes no stall. It is DEPTH register stages, counting the capture edge.
//  - Full: all v=1 and q_ready=0, so data_ready=0 and every stage holds.
//  - Full with q_ready=1: data_ready=1. Simultaneous in and out shift every stage; no bubble.
//  - Empty: q_valid=0 and data_ready=1; q keeps the last delivered word (or RESET_VALUE).
//  - Bubbles collapse: an invalid stage always accepts, so gaps close up behind a stalled head.
//  - Reset mid-operation drops all in-flight words; no partial output is produced.
//  - data/data_valid changes while data_ready=0 are ignored. The source must hold them (AXI-style rule).
// CONFIGURATION
//  DFF_PIPE_OCCUPANCY_EN defined:
//    occupancy port exists, registered, equal to the number of set valid bits.
//    Update: +1 on in-only transfer, -1 on out-only, unchanged on both or neither.
//    Range 0..DEPTH; reset 0.
//  Not defined: occupancy port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package dff_pkg: occ_width function ($clog2(DEPTH+1)) and default WIDTH/DEPTH constants.
//  Sub-module dff_pipe_stage: one data reg + valid bit with async active-low reset.
//    Inputs: up data/valid, advance. Outputs: data, valid.
//    It is instantiated DEPTH times with a generate loop. Top holds the ready chain and the optional counter.
// TESTING
//  1) Hold reset=0 and toggle data -> q=RESET_VALUE, q_valid=0, data_ready=1; reset asserted between clk edges clears at once.
//  2) DEPTH=3, q_ready=1, stream 0x11,0x22,0x33 back-to-back -> q_valid at edges 3,4,5 with q=0x11,0x22,0x33; data_ready stays 1.
//  3) q_ready=0, push 4 words into DEPTH=3 -> first 3 accepted, data_ready=0 on 4th, q=first word held.
//     Then q_ready=1 -> words drain in order, none lost.
//  4) Send 0xA5, idle 2 cycles, send 0x5A, with q_ready low until both are inside -> bubble collapses; words arrive adjacent.
//  5) Full pipe with q_ready=1 and data_valid=1 on the same cycle -> one in and one out; occupancy stays 3 (with DFF_PIPE_OCCUPANCY_EN).
//  6) Drop reset to 0 with 2 words in flight -> q_valid=0 and occupancy=0 immediately; words never appear after release.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the valid/ready register pipeline.
// Build option: DFF_PIPE_OCCUPANCY_EN adds the occupancy counter port.
package dff_pkg;

   localparam int DFF_WIDTH = 8;
   localparam int DFF_DEPTH = 3;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: data register plus valid bit, async active-low reset.
// Bubbles pass through as valid=0 without disturbing the held data.
module dff_pipe_stage
   import dff_pkg::*;
#(
   parameter int               WIDTH       = DFF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] up_data,
   input  logic             up_valid,
   input  logic             advance,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= RESET_VALUE;
      end else if (advance) begin
         valid <= up_valid;
         if (up_valid) begin
            data <= up_data;
         end
      end
   end

endmodule

// File: rtl/dff_pipe_async_reset.sv
// WIDTH x DEPTH valid/ready register pipeline with async active-low reset.
// Build option: DFF_PIPE_OCCUPANCY_EN adds the registered occupancy port.
module dff_pipe_async_reset
   import dff_pkg::*;
#(
   parameter int               WIDTH       = DFF_WIDTH,
   parameter int               DEPTH       = DFF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              data,
   input  logic                          data_valid,
   output logic                          data_ready,
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
`ifdef DFF_PIPE_OCCUPANCY_EN
   output logic [occ_width(DEPTH)-1:0]   occupancy,
`endif
   input  logic                          q_ready
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipe_async_reset: DEPTH must be >= 1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("dff_pipe_async_reset: WIDTH must be >= 1");
   end

   logic [WIDTH-1:0] sd [DEPTH];
   logic [DEPTH-1:0] sv;
   logic [DEPTH:0]   adv;

   // Ready ripples from the output end back to the input end.
   always_comb begin
      adv        = '0;
      adv[DEPTH] = q_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         adv[i] = !sv[i] || adv[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] up_d;
      logic             up_v;
      if (i == 0) begin : g_head
         assign up_d = data;
         assign up_v = data_valid;
      end else begin : g_body
         assign up_d = sd[i-1];
         assign up_v = sv[i-1];
      end
      dff_pipe_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .up_data  (up_d),
         .up_valid (up_v),
         .advance  (adv[i]),
         .data     (sd[i]),
         .valid    (sv[i])
      );
   end

   assign data_ready = adv[0];
   assign q          = sd[DEPTH-1];
   assign q_valid    = sv[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
   logic xfer_in;
   logic xfer_out;

   assign xfer_in  = data_valid && data_ready;
   assign xfer_out = q_valid && q_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occupancy <= '0;
      end else if (xfer_in && !xfer_out) begin
         occupancy <= occupancy + 1'b1;
      end else if (xfer_out && !xfer_in) begin
         occupancy <= occupancy - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dff_pipe_async_reset.sv
// Directed bench for dff_pipe_async_reset (WIDTH=8, DEPTH=3, RESET_VALUE=C3).
// Occupancy checks compile in when DFF_PIPE_OCCUPANCY_EN is defined.
module tb_dff_pipe_async_reset;
   import dff_pkg::*;

   localparam int         W  = 8;
   localparam int         D  = 3;
   localparam logic [7:0] RV = 8'hC3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] data = '0;
   logic         data_valid = 1'b0;
   logic         data_ready;
   logic [W-1:0] q;
   logic         q_valid;
   logic         q_ready = 1'b0;
`ifdef DFF_PIPE_OCCUPANCY_EN
   logic [occ_width(D)-1:0] occupancy;
`endif

   int errs = 0;
   int checks = 0;

   dff_pipe_async_reset #(
      .WIDTH       (W),
      .DEPTH       (D),
      .RESET_VALUE (RV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .q          (q),
      .q_valid    (q_valid),
`ifdef DFF_PIPE_OCCUPANCY_EN
      .occupancy  (occupancy),
`endif
      .q_ready    (q_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic occ(input string tag, input int exp);
`ifdef DFF_PIPE_OCCUPANCY_EN
      check(tag, 32'(occupancy), 32'(exp));
`endif
   endtask

   initial begin
      // 1) held in reset while data toggles
      data_valid = 1'b1;
      q_ready    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data = 8'(i * 8'h35);
         tick();
         check("rst_q", 32'(q), 32'(RV));
         check("rst_qv", 32'(q_valid), 0);
         check("rst_rdy", 32'(data_ready), 1);
         occ("rst_occ", 0);
      end
      data_valid = 1'b0;
      reset = 1'b1;

      // async clear between edges
      data = 8'h77; data_valid = 1'b1;
      tick(); tick(); tick();
      data_valid = 1'b0;
      check("pre_ar_q", 32'(q), 32'h77);
      check("pre_ar_qv", 32'(q_valid), 1);
      #2 reset = 1'b0;
      #1;
      check("ar_qv", 32'(q_valid), 0);
      check("ar_q", 32'(q), 32'(RV));
      occ("ar_occ", 0);
      tick();
      reset = 1'b1;

      // 2) back-to-back stream, q_ready=1
      q_ready = 1'b1;
      data_valid = 1'b1;
      data = 8'h11; #1 check("s_rdy0", 32'(data_ready), 1); tick();
      check("s_e1_qv", 32'(q_valid), 0);
      data = 8'h22; #1 check("s_rdy1", 32'(data_ready), 1); tick();
      check("s_e2_qv", 32'(q_valid), 0);
      data = 8'h33; #1 check("s_rdy2", 32'(data_ready), 1); tick();
      data_valid = 1'b0;
      check("s_e3_qv", 32'(q_valid), 1);
      check("s_e3_q", 32'(q), 32'h11);
      tick();
      check("s_e4_q", 32'(q), 32'h22);
      check("s_e4_qv", 32'(q_valid), 1);
      tick();
      check("s_e5_q", 32'(q), 32'h33);
      check("s_e5_qv", 32'(q_valid), 1);
      tick();
      check("s_e6_qv", 32'(q_valid), 0);
      check("s_e6_q", 32'(q), 32'h33);

      // 3) fill under backpressure, then drain (5: full in+out)
      q_ready = 1'b0;
      data_valid = 1'b1;
      data = 8'hA1; tick();
      data = 8'hA2; tick();
      data = 8'hA3; tick();
      data = 8'hA4; #1;
      check("f_rdy", 32'(data_ready), 0);
      check("f_q", 32'(q), 32'hA1);
      check("f_qv", 32'(q_valid), 1);
      occ("f_occ", 3);
      tick();
      check("f_hold_q", 32'(q), 32'hA1);
      check("f_hold_rdy", 32'(data_ready), 0);
      q_ready = 1'b1; #1;
      check("f_rdy_thru", 32'(data_ready), 1);
      tick();
      data_valid = 1'b0;
      check("d_q2", 32'(q), 32'hA2);
      occ("io_occ", 3);
      tick();
      check("d_q3", 32'(q), 32'hA3);
      tick();
      check("d_q4", 32'(q), 32'hA4);
      check("d_q4v", 32'(q_valid), 1);
      tick();
      check("d_empty", 32'(q_valid), 0);
      occ("d_occ", 0);

      // 4) bubble collapse behind stalled head
      q_ready = 1'b0;
      data_valid = 1'b1; data = 8'hA5; tick();
      data_valid = 1'b0; tick(); tick();
      data_valid = 1'b1; data = 8'h5A; tick();
      data_valid = 1'b0; tick();
      check("b_q", 32'(q), 32'hA5);
      occ("b_occ", 2);
      q_ready = 1'b1;
      tick();
      check("b_q2", 32'(q), 32'h5A);
      check("b_q2v", 32'(q_valid), 1);
      tick();
      check("b_end", 32'(q_valid), 0);

      // 6) reset with two words in flight
      q_ready = 1'b0;
      data_valid = 1'b1; data = 8'hB1; tick();
      data = 8'hB2; tick();
      data_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("m_qv", 32'(q_valid), 0);
      check("m_q", 32'(q), 32'(RV));
      occ("m_occ", 0);
      tick();
      reset = 1'b1;
      q_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("m_gone", 32'(q_valid), 0);
      end
      check("m_q_end", 32'(q), 32'(RV));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
